// File: rtl/adc_seq_pkg.sv
// Shared types and helpers for the ADC sample sequencer: FSM states, widths,
// offset-binary conversion and 12-bit saturation.
package adc_seq_pkg;

    localparam int ADC_DATA_W = 12;
    localparam int ADC_CH_W   = 5;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_TICK,
        CMD,
        RESP
    } seq_state_t;

    typedef struct packed {
        logic [ADC_CH_W-1:0]   channel;
        logic [ADC_DATA_W-1:0] data;
    } adc_resp_t;

    // Offset-binary to two's complement is just an MSB flip (code - 2048).
    function automatic logic [ADC_DATA_W-1:0] offset_to_signed(input logic [ADC_DATA_W-1:0] code);
        return {~code[ADC_DATA_W-1], code[ADC_DATA_W-2:0]};
    endfunction

    function automatic logic [ADC_DATA_W-1:0] sat12(input logic signed [ADC_DATA_W+1:0] v);
        if (v > 14'sd2047)
            return 12'h7ff;
        else if (v < -14'sd2048)
            return 12'h800;
        else
            return v[ADC_DATA_W-1:0];
    endfunction

endpackage

// File: rtl/adc_dc_block.sv
// DC tracker: leaky accumulator of captured samples; output is the sample
// minus the tracked mean, saturated to 12 bits. Purely combinational output.
module adc_dc_block
    import adc_seq_pkg::*;
#(
    parameter int DC_SHIFT = 10
) (
    input  logic                         clock_clk,
    input  logic                         reset_sink_reset,
    input  logic                         capture,
    input  logic signed [ADC_DATA_W-1:0] x,
    output logic        [ADC_DATA_W-1:0] y
);

    localparam int ACC_W = ADC_DATA_W + DC_SHIFT;

    logic signed [ACC_W-1:0]      acc;
    logic signed [ACC_W-1:0]      mean;
    logic signed [ACC_W-1:0]      acc_nxt;
    logic signed [ADC_DATA_W+1:0] diff;

    // mean always fits in 12 signed bits, so the narrowing cast is lossless
    always_comb begin
        mean    = acc >>> DC_SHIFT;
        acc_nxt = acc + ACC_W'(x) - mean;
        diff    = (ADC_DATA_W+2)'(x) - (ADC_DATA_W+2)'(mean);
        y       = sat12(diff);
    end

    always_ff @(posedge clock_clk) begin
        if (reset_sink_reset)
            acc <= '0;
        else if (capture)
            acc <= acc_nxt;
    end

endmodule

// File: rtl/adc_sample_sequencer.sv
// Rate-driven command issuer / response collector for the modular ADC.
// Build option ADC_DCBLOCK_EN inserts the DC tracker on the sample path.
module adc_sample_sequencer
    import adc_seq_pkg::*;
#(
    parameter int CHANNEL  = 1,
    parameter int RATE_DIV = 50,
    parameter int TIMEOUT  = 64,
    parameter int DC_SHIFT = 10
) (
    input  logic                  clock_clk,
    input  logic                  reset_sink_reset,
    input  logic                  enable,
    output logic                  command_valid,
    output logic [ADC_CH_W-1:0]   command_channel,
    output logic                  command_startofpacket,
    output logic                  command_endofpacket,
    input  logic                  command_ready,
    input  logic                  response_valid,
    input  logic [ADC_CH_W-1:0]   response_channel,
    input  logic [ADC_DATA_W-1:0] response_data,
    input  logic                  response_startofpacket,
    input  logic                  response_endofpacket,
    output logic                  sample_valid,
    output logic [ADC_DATA_W-1:0] sample_data,
    input  logic                  sample_ready,
    output logic                  overrun,
    output logic                  tick_miss,
    output logic                  timeout_err,
    input  logic                  err_clear
);

    localparam int RC_W = $clog2(RATE_DIV);
    localparam int TO_W = $clog2(TIMEOUT);

    if (RATE_DIV < 8 || DC_SHIFT < 1) begin : g_bad_cfg
        $error("adc_sample_sequencer: RATE_DIV must be >= 8 and DC_SHIFT >= 1");
    end

    seq_state_t                    state, state_nxt;
    logic [RC_W-1:0]               rate_cnt;
    logic [TO_W-1:0]               to_cnt;
    logic                          tick, cap, to_hit, busy;
    logic signed [ADC_DATA_W-1:0]  x;
    logic [ADC_DATA_W-1:0]         y;
    adc_resp_t                     rsp;
    logic                          unused;

    assign unused = &{1'b0, response_startofpacket, response_endofpacket};

    assign rsp    = '{channel: response_channel, data: response_data};
    assign tick   = enable && (rate_cnt == RC_W'(RATE_DIV - 1));
    assign busy   = (state == CMD) || (state == RESP);
    assign cap    = (state == RESP) && response_valid && (rsp.channel == ADC_CH_W'(CHANNEL));
    // a response landing on the last wait cycle still counts
    assign to_hit = (state == RESP) && !cap && (to_cnt == TO_W'(TIMEOUT - 1));
    assign x      = offset_to_signed(rsp.data);

`ifdef ADC_DCBLOCK_EN
    adc_dc_block #(.DC_SHIFT(DC_SHIFT)) u_dc (
        .clock_clk       (clock_clk),
        .reset_sink_reset(reset_sink_reset),
        .capture         (cap),
        .x               (x),
        .y               (y)
    );
`else
    assign y = x;
`endif

    always_ff @(posedge clock_clk) begin
        if (reset_sink_reset || !enable || tick)
            rate_cnt <= '0;
        else
            rate_cnt <= rate_cnt + RC_W'(1);
    end

    always_ff @(posedge clock_clk) begin
        if (reset_sink_reset) begin
            state  <= IDLE;
            to_cnt <= '0;
        end else begin
            state  <= state_nxt;
            to_cnt <= (state == RESP) ? to_cnt + TO_W'(1) : '0;
        end
    end

    always_comb begin
        state_nxt     = state;
        command_valid = 1'b0;
        case (state)
            IDLE:      if (enable) state_nxt = WAIT_TICK;
            WAIT_TICK: begin
                if (!enable)   state_nxt = IDLE;
                else if (tick) state_nxt = CMD;
            end
            CMD: begin
                command_valid = 1'b1;
                if (command_ready) state_nxt = RESP;
            end
            RESP:      if (cap || to_hit) state_nxt = enable ? WAIT_TICK : IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    assign command_channel       = command_valid ? ADC_CH_W'(CHANNEL) : '0;
    assign command_startofpacket = command_valid;
    assign command_endofpacket   = command_valid;

    // single-entry output register; a capture may refill it on the draining cycle
    always_ff @(posedge clock_clk) begin
        if (reset_sink_reset) begin
            sample_valid <= 1'b0;
            sample_data  <= '0;
        end else if (cap && (!sample_valid || sample_ready)) begin
            sample_valid <= 1'b1;
            sample_data  <= y;
        end else if (sample_valid && sample_ready) begin
            sample_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock_clk) begin
        if (reset_sink_reset) begin
            overrun     <= 1'b0;
            tick_miss   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            overrun     <= (cap && sample_valid && !sample_ready) || (overrun && !err_clear);
            tick_miss   <= (tick && busy) || (tick_miss && !err_clear);
            timeout_err <= to_hit || (timeout_err && !err_clear);
        end
    end

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Randomized bench for adc_sample_sequencer against a transaction-level model
// of sample timing, conversion, output slot and sticky flags.
module tb_adc_sample_sequencer;

`ifdef ADC_DCBLOCK_EN
    localparam int RD = 8;
`else
    localparam int RD = 50;
`endif
    localparam int CH = 1;
    localparam int TO = 64;
    localparam int DS = 10;

    logic        clk = 1'b0, rst = 1'b1;
    logic        enable = 1'b0, command_ready = 1'b0, response_valid = 1'b0;
    logic [4:0]  response_channel = '0;
    logic [11:0] response_data = '0;
    logic        sample_ready = 1'b0, err_clear = 1'b0, resp_sop;
    logic        command_valid, command_startofpacket, command_endofpacket;
    logic [4:0]  command_channel;
    logic        sample_valid, overrun, tick_miss, timeout_err;
    logic [11:0] sample_data;

    assign resp_sop = response_valid;
    always #5 clk = ~clk;

    adc_sample_sequencer #(.CHANNEL(CH), .RATE_DIV(RD), .TIMEOUT(TO), .DC_SHIFT(DS)) dut (
        .clock_clk(clk), .reset_sink_reset(rst), .enable(enable),
        .command_valid(command_valid), .command_channel(command_channel),
        .command_startofpacket(command_startofpacket), .command_endofpacket(command_endofpacket),
        .command_ready(command_ready), .response_valid(response_valid),
        .response_channel(response_channel), .response_data(response_data),
        .response_startofpacket(resp_sop), .response_endofpacket(resp_sop),
        .sample_valid(sample_valid), .sample_data(sample_data), .sample_ready(sample_ready),
        .overrun(overrun), .tick_miss(tick_miss), .timeout_err(timeout_err), .err_clear(err_clear)
    );

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // model: 0 = waiting for a tick, 1 = command offered, 2 = awaiting response
    int          phase = 0, age = 0, en_run = 0;
    bit          exp_sv = 0, exp_ov = 0, exp_tm = 0, exp_to = 0;
    logic [11:0] exp_sd = '0;
    int          dq[$];

    // stimulus knobs
    int          resp_delay = 3, rdy_pct = 100, srdy_pct = 100, clr_pm = 0, const_code = -1;
    logic [4:0]  resp_chan = 5'(CH);
    bit          rnd = 0, drain_on_resp = 0, force_clr = 0;

`ifdef ADC_DCBLOCK_EN
    longint      acc = 0;
    logic signed [11:0] last_sd = '0;
`endif

    function automatic logic [11:0] conv(input logic [11:0] c);
        int x;
        x = int'(c) - 2048;
`ifdef ADC_DCBLOCK_EN
        begin
            int m, v;
            m   = int'(acc >>> DS);
            acc = acc + x - m;
            v   = x - m;
            if (v > 2047) v = 2047;
            if (v < -2048) v = -2048;
            return 12'(v);
        end
`else
        return 12'(x);
`endif
    endfunction

    task automatic step();
        bit          en_p, crdy_p, rv_p, srdy_p, clr_p, tk, capn;
        logic [4:0]  ch_p;
        logic [11:0] d_p, y;
        en_p = enable; crdy_p = command_ready; rv_p = response_valid;
        srdy_p = sample_ready; clr_p = err_clear; ch_p = response_channel; d_p = response_data;
        @(posedge clk);
        #1;
        en_run = en_p ? en_run + 1 : 0;
        tk = en_p && (en_run % RD == 0);
        if (clr_p) begin exp_ov = 0; exp_tm = 0; exp_to = 0; end
        capn = 0;
        if (phase == 1) begin
            if (tk) exp_tm = 1;
            if (crdy_p) begin
                phase = 2;
                age   = 0;
                if (rnd) begin
                    resp_delay = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 80))
                                                             : int'($urandom_range(0, 6));
                    resp_chan  = ($urandom_range(0, 15) == 0) ? 5'd3 : 5'(CH);
                end
            end
        end else if (phase == 2) begin
            age++;
            if (tk) exp_tm = 1;
            if (rv_p && ch_p == 5'(CH)) begin capn = 1; phase = 0; end
            else if (age == TO) begin exp_to = 1; phase = 0; end
        end else if (tk) begin
            phase = 1;
        end
        if (exp_sv && srdy_p) exp_sv = 0;
        if (capn) begin
            y = conv(d_p);
            if (exp_sv) exp_ov = 1;
            else begin exp_sv = 1; exp_sd = y; end
        end

        chk("cmd_valid", 32'(command_valid), 32'(phase == 1));
        chk("cmd_sop", 32'(command_startofpacket), 32'(phase == 1));
        chk("cmd_eop", 32'(command_endofpacket), 32'(phase == 1));
        chk("cmd_chan", 32'(command_channel), (phase == 1) ? 32'(CH) : 32'd0);
        chk("smp_valid", 32'(sample_valid), 32'(exp_sv));
        if (exp_sv) chk("smp_data", 32'(sample_data), 32'(exp_sd));
        chk("overrun", 32'(overrun), 32'(exp_ov));
        chk("tick_miss", 32'(tick_miss), 32'(exp_tm));
        chk("timeout_err", 32'(timeout_err), 32'(exp_to));
`ifdef ADC_DCBLOCK_EN
        if (sample_valid) last_sd = sample_data;
`endif

        if (rnd && $urandom_range(0, 299) == 0) enable = ~enable;
        response_valid   = 1'b0;
        response_channel = 5'($urandom_range(0, 31));
        response_data    = 12'($urandom);
        if (phase == 2 && resp_delay >= 0 && age == resp_delay) begin
            response_valid   = 1'b1;
            response_channel = resp_chan;
            if (dq.size() > 0) response_data = 12'(dq.pop_front());
            else if (const_code >= 0) response_data = 12'(const_code);
        end else if (rnd && phase != 2 && $urandom_range(0, 9) == 0) begin
            response_valid = 1'b1;
        end
        command_ready = ($urandom_range(1, 100) <= rdy_pct);
        sample_ready  = drain_on_resp ? response_valid : ($urandom_range(1, 100) <= srdy_pct);
        err_clear     = force_clr || ($urandom_range(1, 1000) <= clr_pm);
        force_clr     = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_cmd();
        for (int i = 0; i < 4 * RD && phase != 1; i++) step();
        chk("wait_cmd", 32'(command_valid), 32'd1);
    endtask

    task automatic clear_flags();
        force_clr = 1;
        run(2);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_valid", 32'(command_valid), 0);
        chk("rst_cmd_chan", 32'(command_channel), 0);
        chk("rst_cmd_sop", 32'(command_startofpacket), 0);
        chk("rst_cmd_eop", 32'(command_endofpacket), 0);
        chk("rst_smp_valid", 32'(sample_valid), 0);
        chk("rst_smp_data", 32'(sample_data), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_tick_miss", 32'(tick_miss), 0);
        chk("rst_timeout", 32'(timeout_err), 0);
        rst = 1'b0;

        // steady sampling with known codes, including both conversion extremes
        dq = '{'h800, 'h800, 'h800, 'hFFF, 'h000, 'h801, 'h7FF};
        enable = 1'b1;
        run(9 * RD);

        // command stalled across a tick
        rdy_pct = 0;
        wait_cmd();
        run(60);
        rdy_pct = 100;
        run(2 * RD);
        clear_flags();

        // no response -> timeout, then normal traffic resumes
        resp_delay = -1;
        wait_cmd();
        run(TO + 4);
        resp_delay = 3;
        run(3 * RD);
        clear_flags();

        // response on the very last wait cycle is still accepted
        resp_delay = TO - 1;
        wait_cmd();
        run(TO + 4);
        resp_delay = 3;
        clear_flags();

        // wrong channel is ignored and ends in timeout
        resp_chan = 5'd3;
        wait_cmd();
        run(TO + 8);
        resp_chan = 5'(CH);
        run(2 * RD);
        clear_flags();

        // output back-pressure across captures -> overrun, then drain
        srdy_pct = 0;
        run(3 * RD);
        srdy_pct = 100;
        run(RD);
        clear_flags();

        // drain and refill on the same edge -> no overrun
        drain_on_resp = 1;
        run(4 * RD);
        drain_on_resp = 0;
        run(RD);

        // enable dropped while the command is stalled: transaction still completes
        rdy_pct = 0;
        wait_cmd();
        enable = 1'b0;
        run(5);
        rdy_pct = 100;
        run(2 * RD);
        enable = 1'b1;
        run(2 * RD);
        clear_flags();

        // random traffic
        rnd = 1; rdy_pct = 70; srdy_pct = 60; clr_pm = 5;
        run(12000);
        rnd = 0; rdy_pct = 100; srdy_pct = 100; clr_pm = 0;
        resp_delay = 3; resp_chan = 5'(CH);
        run(TO + 4);

`ifdef ADC_DCBLOCK_EN
        // constant +512 input settles toward zero
        enable = 1'b1;
        const_code = 'hA00;
        run(7000 * RD);
        chk("dc_settled", 32'(($signed(last_sd) <= 2) && ($signed(last_sd) >= -2)), 32'd1);
        const_code = -1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_sample_sequencer.md
Name: adc_sample_sequencer

Overview:
- Upstream/downstream companion of the modular ADC IP (command/response Avalon-ST).
- Issues single-channel conversion commands at a programmable sample rate and collects the matching responses.
- Converts offset-binary 12-bit codes to two's-complement samples.
- Presents samples to the SDR front end on a valid/ready stream, with sticky error flags.

Parameters:
- CHANNEL, 1, ADC channel number placed on command_channel.
- RATE_DIV, 50, sample period in clock_clk cycles; must be >= 8.
- TIMEOUT, 64, max clocks to wait for a response before abandoning the conversion.
- DC_SHIFT, 10, DC-tracker time-constant shift; used only with the optional feature.

Ports:
- clock_clk  in  1  system clock; same domain as the ADC command/response interface.
- reset_sink_reset  in  1  synchronous, active-high reset.
- enable  in  1  run/stop sampling.
- command_valid  out  1  conversion request valid.
- command_channel  out  5  channel to convert (CHANNEL).
- command_startofpacket  out  1  tied 1 while command_valid.
- command_endofpacket  out  1  tied 1 while command_valid.
- command_ready  in  1  ADC accepts the command.
- response_valid  in  1  conversion result valid.
- response_channel  in  5  channel of the result.
- response_data  in  12  unsigned offset-binary code.
- response_startofpacket  in  1  ignored.
- response_endofpacket  in  1  ignored.
- sample_valid  out  1  output sample valid.
- sample_data  out  12  signed two's-complement sample.
- sample_ready  in  1  downstream accepts the sample.
- overrun  out  1  sticky: a sample was dropped because the output was still full.
- tick_miss  out  1  sticky: a rate tick arrived while a conversion was still in flight.
- timeout_err  out  1  sticky: a response timed out.
- err_clear  in  1  clears all three sticky flags.

Behaviour:
- Reset: all outputs 0; state IDLE; rate counter 0; timeout counter 0; DC accumulator 0.
- Rate counter:
  - Counts 0..RATE_DIV-1 while enable=1, then wraps.
  - tick = 1 for one cycle when count==RATE_DIV-1.
  - enable=0 holds the counter at 0.
- States:
  - IDLE: waits for enable=1, then goes to WAIT_TICK.
  - WAIT_TICK: on tick, goes to CMD. If enable drops, goes to IDLE.
  - CMD: command_valid=1 and holds until command_ready=1 on the same cycle (transfer); then goes to RESP.
  - RESP: timeout counter starts at 0.
    - On response_valid with response_channel==CHANNEL: capture the sample, go to WAIT_TICK.
    - A response with a mismatched channel is ignored.
    - When the counter reaches TIMEOUT-1: set timeout_err, go to WAIT_TICK.
- enable dropping in CMD or RESP: the current transaction finishes, then the block goes to IDLE instead of WAIT_TICK. command_valid is never withdrawn before command_ready.
- tick arriving in CMD or RESP: set tick_miss. The tick is not queued.
- Conversion: sample_data = {~response_data[11], response_data[10:0]}, i.e. code−2048.
- Capture latency: sample_valid rises 1 cycle after the accepted response_valid.
- Output register:
  - Holds the sample until sample_valid && sample_ready.
  - New capture while the register is full and not being drained that cycle: drop the new sample, set overrun, keep the old sample.
  - New capture on the same cycle the held sample drains: accept the new sample, no overrun.
- Sticky flags:
  - Clear on err_clear.
  - A set event on the same cycle as err_clear wins: the flag ends at 1.

Optional Feature:
- Macro ADC_DCBLOCK_EN.
- Defined: the block keeps a signed accumulator of 12+DC_SHIFT bits.
  - On each captured sample x: acc <= acc + x − (acc >>> DC_SHIFT).
  - Output sample = sat12(x − (acc >>> DC_SHIFT)), saturated to [−2048, 2047].
  - Latency is unchanged: the combinational subtract happens at capture.
- Not defined: the output is the raw converted sample and no accumulator exists.

Decomposition:
- Package adc_seq_pkg:
  - state enum (IDLE, WAIT_TICK, CMD, RESP).
  - constants ADC_DATA_W=12 and ADC_CH_W=5.
  - function offset-to-signed.
  - function sat12.
- Sub-module adc_dc_block (accumulator plus subtract/saturate), instantiated only under ADC_DCBLOCK_EN.

Test Plan:
- RATE_DIV=50, enable=1, command_ready always 1, response 3 clocks after the command with data 0x800 -> one command every 50 clocks; sample_data=0x000 one cycle after each response.
- Response data 0xFFF, then 0x000 -> sample_data=0x7FF, then 0x800; command_startofpacket and command_endofpacket are 1 with command_valid.
- command_ready held low for 60 clocks -> command_valid stays 1 throughout; tick_miss=1 after the next tick; err_clear clears it.
- No response after the command, TIMEOUT=64 -> timeout_err=1 at 64 clocks; the next tick issues a new command.
- sample_ready=0 across two captures -> first sample held, overrun=1, second sample dropped. Drain and capture on the same cycle -> no overrun.
- ADC_DCBLOCK_EN, constant code 0xA00 (x=+512) for 20000 samples -> output decays toward 0 with |out|<=2 at the end. Response on channel 3 with CHANNEL=1 -> ignored, and the block times out.
